// File: rtl/ws2812b_frame_arbiter_pkg.sv
// Shared definitions for the WS2812B frame arbiter: source/state encodings and bus payloads.
package ws2812b_frame_arbiter_pkg;

   localparam int unsigned COL_W = 8;
   localparam int unsigned CNT_W = 8;
   localparam int unsigned FC_W  = 16;

   // active_src encoding, also used by the game core and bench
   localparam logic [1:0] SRC_GAME  = 2'd0;
   localparam logic [1:0] SRC_ANIM  = 2'd1;
   localparam logic [1:0] SRC_BLANK = 2'd2;

   // State encoding equals the active_src encoding so the owner output is the state itself
   typedef enum logic [1:0] {
      S_GAME  = SRC_GAME,
      S_ANIM  = SRC_ANIM,
      S_BLANK = SRC_BLANK
   } state_t;

   typedef struct packed {
      logic [COL_W-1:0] red;
      logic [COL_W-1:0] green;
      logic [COL_W-1:0] blue;
   } rgb_t;

endpackage

// File: rtl/ws2812b_frame_arbiter_frame_hold_counter.sv
// Saturating count of frames owned by the current source, with the minimum-hold comparison.
module frame_hold_counter
   import ws2812b_frame_arbiter_pkg::*;
#(
   parameter int unsigned MIN_HOLD_FRAMES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic inc,
   output logic hold_ok_c
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // The frame ending now counts toward the hold, hence the +1 (one bit wider to avoid overflow)
   assign hold_ok_c = ((CNT_W+1)'(cnt_q) + (CNT_W+1)'(1)) >= (CNT_W+1)'(MIN_HOLD_FRAMES);

endmodule

// File: rtl/ws2812b_frame_arbiter.sv
// Shares the WS2812B strip driver between the game core and the animation generator,
// switching ownership only at frame boundaries with a minimum hold and black gap frames.
module ws2812b_frame_arbiter
   import ws2812b_frame_arbiter_pkg::*;
#(
   parameter  int unsigned MAX_POS         = 109,
   parameter  int unsigned MIN_HOLD_FRAMES = 4,
   parameter  int unsigned BLANK_FRAMES    = 1,
   localparam int unsigned LW              = $clog2(MAX_POS)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [LW-1:0]   drv_led_number,
   input  logic            drv_update_frame,
   output logic [7:0]      drv_red,
   output logic [7:0]      drv_green,
   output logic [7:0]      drv_blue,
   output logic [LW-1:0]   game_led_number,
   input  logic [7:0]      game_red,
   input  logic [7:0]      game_green,
   input  logic [7:0]      game_blue,
   output logic            game_update_frame,
   input  logic            anim_req,
   output logic [LW-1:0]   anim_led_number,
   input  logic [7:0]      anim_red,
   input  logic [7:0]      anim_green,
   input  logic [7:0]      anim_blue,
   output logic            anim_update_frame,
   output logic [1:0]      active_src,
   output logic [15:0]     frame_count
);

   localparam state_t           RESET_STATE = (BLANK_FRAMES > 0) ? S_BLANK : S_GAME;
   localparam logic [CNT_W-1:0] BLANK_INIT  = CNT_W'(BLANK_FRAMES);

   state_t           state_q, state_d;
   logic             target_anim_q, target_anim_d;
   logic [CNT_W-1:0] blank_cnt_q, blank_cnt_d;
   logic [FC_W-1:0]  frame_count_q, frame_count_d;

   logic hold_ok_c;
   logic hold_clr_c;
   logic hold_inc_c;
   logic switch_c;
   logic switch_to_anim_c;
   rgb_t col_c;

   frame_hold_counter #(
      .MIN_HOLD_FRAMES (MIN_HOLD_FRAMES)
   ) u_hold (
      .clk       (clk),
      .reset     (reset),
      .clr       (hold_clr_c),
      .inc       (hold_inc_c),
      .hold_ok_c (hold_ok_c)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= RESET_STATE;
         target_anim_q <= 1'b0;
         blank_cnt_q   <= BLANK_INIT;
         frame_count_q <= '0;
      end else begin
         state_q       <= state_d;
         target_anim_q <= target_anim_d;
         blank_cnt_q   <= blank_cnt_d;
         frame_count_q <= frame_count_d;
      end
   end

   // Ownership decision; everything holds between frame boundaries
   always_comb begin
      state_d          = state_q;
      target_anim_d    = target_anim_q;
      blank_cnt_d      = blank_cnt_q;
      frame_count_d    = frame_count_q;
      switch_c         = 1'b0;
      switch_to_anim_c = 1'b0;
      hold_clr_c       = 1'b0;
      hold_inc_c       = 1'b0;

      if (drv_update_frame) begin
         frame_count_d = frame_count_q + FC_W'(1);
         case (state_q)
            S_GAME: begin
               if (anim_req && hold_ok_c) begin
                  switch_c         = 1'b1;
                  switch_to_anim_c = 1'b1;
               end
            end
            S_ANIM: begin
               if (!anim_req && hold_ok_c) begin
                  switch_c = 1'b1;
               end
            end
            S_BLANK: begin
               // Target is latched on entry, so anim_req cannot redirect a gap in progress
               if (blank_cnt_q <= CNT_W'(1)) begin
                  blank_cnt_d = '0;
                  state_d     = target_anim_q ? S_ANIM : S_GAME;
               end else begin
                  blank_cnt_d = blank_cnt_q - CNT_W'(1);
               end
            end
            default: state_d = RESET_STATE;
         endcase

         if (switch_c) begin
            if (BLANK_FRAMES == 0) begin
               state_d = switch_to_anim_c ? S_ANIM : S_GAME;
            end else begin
               state_d       = S_BLANK;
               target_anim_d = switch_to_anim_c;
               blank_cnt_d   = BLANK_INIT;
            end
         end

         hold_clr_c = (state_d != state_q);
         hold_inc_c = !hold_clr_c;
      end
   end

   // Zero-latency colour mux toward the driver
   always_comb begin
      col_c = '0;
      case (state_q)
         S_GAME:  col_c = '{red: game_red, green: game_green, blue: game_blue};
         S_ANIM:  col_c = '{red: anim_red, green: anim_green, blue: anim_blue};
         default: col_c = '0;
      endcase
   end

   assign drv_red           = col_c.red;
   assign drv_green         = col_c.green;
   assign drv_blue          = col_c.blue;
   assign game_led_number   = drv_led_number;
   assign anim_led_number   = drv_led_number;
   assign game_update_frame = drv_update_frame && (state_q == S_GAME);
   assign anim_update_frame = drv_update_frame && (state_q == S_ANIM);
   assign active_src        = 2'(state_q);
   assign frame_count       = frame_count_q;

endmodule

// File: tb/tb_ws2812b_frame_arbiter.sv
// Self-checking bench for ws2812b_frame_arbiter against a frame-level ownership model.
module tb_ws2812b_frame_arbiter;
   import ws2812b_frame_arbiter_pkg::*;

   localparam int unsigned MAX_POS  = 109;
   localparam int unsigned LW       = $clog2(MAX_POS);
   localparam int          MIN_HOLD = 4;
   localparam int          BLANK    = 1;

   logic          clk = 1'b0;
   logic          reset;
   logic [LW-1:0] drv_led_number;
   logic          drv_update_frame;
   logic [7:0]    drv_red, drv_green, drv_blue;
   logic [LW-1:0] game_led_number, anim_led_number;
   logic [7:0]    game_red, game_green, game_blue;
   logic [7:0]    anim_red, anim_green, anim_blue;
   logic          game_update_frame, anim_update_frame;
   logic          anim_req;
   logic [1:0]    active_src;
   logic [15:0]   frame_count;

   int tests_run    = 0;
   int tests_failed = 0;

   // Frame-level model: owner (0 game, 1 anim, 2 blank), frames owned, gap frames left, gap target
   int m_src, m_hold, m_blank, m_tgt, m_fc;

   always #5 clk = ~clk;

   ws2812b_frame_arbiter dut (
      .clk               (clk),
      .reset             (reset),
      .drv_led_number    (drv_led_number),
      .drv_update_frame  (drv_update_frame),
      .drv_red           (drv_red),
      .drv_green         (drv_green),
      .drv_blue          (drv_blue),
      .game_led_number   (game_led_number),
      .game_red          (game_red),
      .game_green        (game_green),
      .game_blue         (game_blue),
      .game_update_frame (game_update_frame),
      .anim_req          (anim_req),
      .anim_led_number   (anim_led_number),
      .anim_red          (anim_red),
      .anim_green        (anim_green),
      .anim_blue         (anim_blue),
      .anim_update_frame (anim_update_frame),
      .active_src        (active_src),
      .frame_count       (frame_count)
   );

   task automatic model_reset();
      m_src   = (BLANK > 0) ? 2 : 0;
      m_tgt   = 0;
      m_blank = BLANK;
      m_hold  = 0;
      m_fc    = 0;
   endtask

   task automatic model_boundary(input bit req);
      int nxt;
      bit ok;
      ok    = (m_hold + 1) >= MIN_HOLD;
      nxt   = m_src;
      m_fc  = (m_fc + 1) % 65536;
      if ((m_src == 0 && req && ok) || (m_src == 1 && !req && ok)) begin
         m_tgt = 1 - m_src;
         if (BLANK == 0) nxt = m_tgt;
         else begin
            nxt     = 2;
            m_blank = BLANK;
         end
      end else if (m_src == 2) begin
         m_blank = m_blank - 1;
         if (m_blank <= 0) nxt = m_tgt;
      end
      if (nxt != m_src) m_hold = 0;
      else if (m_hold < 255) m_hold = m_hold + 1;
      m_src = nxt;
   endtask

   function automatic logic [23:0] model_rgb();
      if (m_src == 0) return {game_red, game_green, game_blue};
      if (m_src == 1) return {anim_red, anim_green, anim_blue};
      return 24'h0;
   endfunction

   // One frame boundary: pulse, sample forwarded pulses, advance the model
   task automatic do_boundary(output logic gp, output logic ap);
      bit req;
      @(negedge clk);
      drv_update_frame = 1'b1;
      #1;
      gp  = game_update_frame;
      ap  = anim_update_frame;
      req = anim_req;
      @(negedge clk);
      drv_update_frame = 1'b0;
      model_boundary(req);
   endtask

   task automatic test_reset();
      logic gp, ap;
      reset = 1'b0; drv_update_frame = 1'b0; anim_req = 1'b0; drv_led_number = '0;
      game_red = 8'h11; game_green = 8'h22; game_blue = 8'h33;
      anim_red = 8'h44; anim_green = 8'h55; anim_blue = 8'h66;
      model_reset();
      #12;
      tests_run++;
      if (active_src !== SRC_BLANK) begin
         tests_failed++; $display("FAIL reset_src: got %0d want %0d", active_src, SRC_BLANK);
      end
      tests_run++;
      if ({drv_red, drv_green, drv_blue} !== 24'h0) begin
         tests_failed++; $display("FAIL reset_rgb: got %h want 0", {drv_red, drv_green, drv_blue});
      end
      tests_run++;
      if (frame_count !== 16'h0 || game_update_frame !== 1'b0 || anim_update_frame !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_fc_pulses: fc=%h gp=%b ap=%b want 0", frame_count, game_update_frame, anim_update_frame);
      end
      @(negedge clk); reset = 1'b1;
      repeat (3) @(negedge clk);
      drv_led_number = LW'(17);
      #1;
      tests_run++;
      if (active_src !== SRC_BLANK || {drv_red, drv_green, drv_blue} !== 24'h0) begin
         tests_failed++;
         $display("FAIL pre_boundary: src=%0d rgb=%h want 2/0", active_src, {drv_red, drv_green, drv_blue});
      end
      do_boundary(gp, ap);
      tests_run++;
      if (gp !== 1'b0 || ap !== 1'b0) begin
         tests_failed++; $display("FAIL first_pulse: gp=%b ap=%b want 0/0", gp, ap);
      end
      tests_run++;
      if (active_src !== SRC_GAME || frame_count !== 16'd1 || {drv_red, drv_green, drv_blue} !== 24'h112233) begin
         tests_failed++;
         $display("FAIL first_boundary: src=%0d fc=%0d rgb=%h want 0/1/112233",
                  active_src, frame_count, {drv_red, drv_green, drv_blue});
      end
   endtask

   task automatic test_switch_to_anim();
      logic gp, ap;
      int game_pulses, n;
      game_pulses = 0; n = 0;
      repeat (2) begin
         do_boundary(gp, ap);
         game_pulses += int'(gp);
      end
      @(negedge clk); anim_req = 1'b1;
      while (n < 10 && active_src != SRC_BLANK) begin
         do_boundary(gp, ap);
         game_pulses += int'(gp);
         n++;
      end
      tests_run++;
      if (n !== 2 || game_pulses !== MIN_HOLD || active_src !== SRC_BLANK) begin
         tests_failed++;
         $display("FAIL switch_hold: req_frames=%0d game_pulses=%0d src=%0d want 2/%0d/2",
                  n, game_pulses, active_src, MIN_HOLD);
      end
      do_boundary(gp, ap);
      tests_run++;
      if (gp !== 1'b0 || ap !== 1'b0 || active_src !== SRC_ANIM || int'(active_src) !== m_src) begin
         tests_failed++;
         $display("FAIL blank_to_anim: gp=%b ap=%b src=%0d want 0/0/1", gp, ap, active_src);
      end
   endtask

   task automatic test_colour_mux();
      logic [LW-1:0] led;
      game_red = 8'h55; anim_red = 8'hAA;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         led            = LW'($urandom_range(MAX_POS - 1, 0));
         drv_led_number = led;
         anim_green     = 8'($urandom);
         anim_blue      = 8'($urandom);
         game_green     = 8'($urandom);
         #1;
         tests_run++;
         if (drv_red !== 8'hAA || {drv_green, drv_blue} !== {anim_green, anim_blue} ||
             game_led_number !== led || anim_led_number !== led) begin
            tests_failed++;
            $display("FAIL anim_mux: rgb=%h want aa%h%h led g/a=%0d/%0d want %0d",
                     {drv_red, drv_green, drv_blue}, anim_green, anim_blue,
                     game_led_number, anim_led_number, led);
         end
      end
   endtask

   task automatic test_anim_release();
      logic gp, ap;
      int n, g;
      do_boundary(gp, ap);
      tests_run++;
      if (ap !== 1'b1 || gp !== 1'b0) begin
         tests_failed++; $display("FAIL anim_pulse: gp=%b ap=%b want 0/1", gp, ap);
      end
      @(negedge clk); anim_req = 1'b0;
      n = 0;
      while (n < 10 && active_src == SRC_ANIM) begin
         do_boundary(gp, ap);
         n++;
      end
      tests_run++;
      if (n !== MIN_HOLD - 1 || active_src !== SRC_BLANK) begin
         tests_failed++;
         $display("FAIL anim_release: frames=%0d src=%0d want %0d/2", n, active_src, MIN_HOLD - 1);
      end
      @(negedge clk); anim_req = 1'b1;
      do_boundary(gp, ap);
      tests_run++;
      if (active_src !== SRC_GAME || gp !== 1'b0 || ap !== 1'b0) begin
         tests_failed++;
         $display("FAIL blank_ignores_req: src=%0d gp=%b ap=%b want 0/0/0", active_src, gp, ap);
      end
      g = 0;
      while (g < 10 && active_src == SRC_GAME) begin
         do_boundary(gp, ap);
         g++;
      end
      tests_run++;
      if (g !== MIN_HOLD || active_src !== SRC_BLANK) begin
         tests_failed++;
         $display("FAIL game_rehold: frames=%0d src=%0d want %0d/2", g, active_src, MIN_HOLD);
      end
      @(negedge clk); anim_req = 1'b0;
   endtask

   task automatic test_midframe_req();
      logic gp, ap;
      int n;
      n = 0;
      while (n < 20 && m_src != 0) begin
         do_boundary(gp, ap);
         n++;
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); anim_req = 1'b1;
         @(negedge clk); anim_req = 1'b0;
         do_boundary(gp, ap);
         tests_run++;
         if (gp !== 1'b1 || ap !== 1'b0 || active_src !== SRC_GAME) begin
            tests_failed++;
            $display("FAIL midframe_req[%0d]: gp=%b ap=%b src=%0d want 1/0/0", i, gp, ap, active_src);
         end
      end
   endtask

   task automatic test_random();
      logic gp, ap;
      logic egp, eap;
      for (int i = 0; i < 300; i++) begin
         repeat ($urandom_range(3, 0)) begin
            @(negedge clk);
            drv_led_number = LW'($urandom_range(MAX_POS - 1, 0));
            {game_red, game_green, game_blue} = 24'($urandom);
            {anim_red, anim_green, anim_blue} = 24'($urandom);
            if ($urandom_range(3, 0) == 0) anim_req = ~anim_req;
            #1;
            tests_run++;
            if ({drv_red, drv_green, drv_blue} !== model_rgb() || int'(active_src) !== m_src) begin
               tests_failed++;
               $display("FAIL rand_frame[%0d]: rgb=%h src=%0d want %h/%0d",
                        i, {drv_red, drv_green, drv_blue}, active_src, model_rgb(), m_src);
            end
         end
         egp = (m_src == 0);
         eap = (m_src == 1);
         do_boundary(gp, ap);
         tests_run++;
         if (gp !== egp || ap !== eap || int'(active_src) !== m_src || int'(frame_count) !== m_fc) begin
            tests_failed++;
            $display("FAIL rand_boundary[%0d]: gp=%b ap=%b src=%0d fc=%0d want %b/%b/%0d/%0d",
                     i, gp, ap, active_src, frame_count, egp, eap, m_src, m_fc);
         end
      end
   endtask

   task automatic test_wrap();
      logic gp, ap;
      int n;
      @(negedge clk); anim_req = 1'b0;
      n = 65535 - m_fc;
      drv_update_frame = 1'b1;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         model_boundary(anim_req);
      end
      drv_update_frame = 1'b0;
      #1;
      tests_run++;
      if (frame_count !== 16'hFFFF || int'(active_src) !== m_src) begin
         tests_failed++;
         $display("FAIL wrap_top: fc=%h src=%0d want ffff/%0d", frame_count, active_src, m_src);
      end
      do_boundary(gp, ap);
      tests_run++;
      if (frame_count !== 16'h0000 || m_fc !== 0) begin
         tests_failed++; $display("FAIL wrap_zero: fc=%h want 0000", frame_count);
      end
   endtask

   task automatic test_reset_midframe();
      logic gp, ap;
      @(negedge clk);
      drv_led_number = LW'(5);
      game_red = 8'h12; game_green = 8'h34; game_blue = 8'h56;
      #2 reset = 1'b0;
      drv_update_frame = 1'b1;
      #1;
      tests_run++;
      if ({drv_red, drv_green, drv_blue} !== 24'h0 || active_src !== SRC_BLANK || frame_count !== 16'h0 ||
          game_update_frame !== 1'b0 || anim_update_frame !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_midframe: rgb=%h src=%0d fc=%h gp=%b ap=%b want 0/2/0/0/0",
                  {drv_red, drv_green, drv_blue}, active_src, frame_count, game_update_frame, anim_update_frame);
      end
      @(negedge clk);
      drv_update_frame = 1'b0;
      reset = 1'b1;
      model_reset();
      do_boundary(gp, ap);
      tests_run++;
      if (active_src !== SRC_GAME || frame_count !== 16'd1 || gp !== 1'b0) begin
         tests_failed++;
         $display("FAIL post_reset: src=%0d fc=%0d gp=%b want 0/1/0", active_src, frame_count, gp);
      end
   endtask

   initial begin
      test_reset();
      test_switch_to_anim();
      test_colour_mux();
      test_anim_release();
      test_midframe_req();
      test_random();
      test_wrap();
      test_reset_midframe();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
